// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the two-requester ALU arbiter.
//   - ALU operation codes (ADD..SRL) and OP_MAX, the highest legal code
//   - FSM state type used by alu_arbiter
package alu_arb_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_SLL = 4'd3;
    localparam logic [3:0] OP_SRL = 4'd4;
    localparam logic [3:0] OP_MAX = OP_SRL;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_arb.sv
// alu_rr_arb: two-way round-robin grant.
//   valid0, valid1 : requests pending
//   last_grant     : requester granted most recently (0 or 1)
//   grant[1:0]     : one-hot grant, all-zero when nothing is valid
// On a tie the requester that was not granted last wins.
module alu_rr_arb (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant    = 2'b00;
        grant[0] = valid0 & (~valid1 | last_grant);
        grant[1] = valid1 & (~valid0 | ~last_grant);
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   clk, reset                 : clock, asynchronous active-high reset
//   reqN_valid_i/ready_o       : request handshake, ready is combinational in IDLE
//   reqN_op_i, reqN_a_i/b_i    : op code and operands of requester N
//   alu_operation_o, alu_a/b_o : drive to the shared ALU, non-zero only in EXEC
//   alu_result_i               : ALU result, captured at the end of EXEC
//   rsp_valid_i/ready_i, rsp_id_o, rsp_data_o, rsp_err_o : response channel
//   grantN_cnt_o               : wrapping count of accepted requests per requester
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | arbitrate, accept one request, latch its op and operands
// EXEC  | latched op on the ALU for one cycle, result captured
// RESP  | response held until rsp_ready_i
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid_i,
    input  logic                  req1_valid_i,
    output logic                  req0_ready_o,
    output logic                  req1_ready_o,
    input  logic [3:0]            req0_op_i,
    input  logic [3:0]            req1_op_i,
    input  logic [DATA_WIDTH-1:0] req0_a_i,
    input  logic [DATA_WIDTH-1:0] req0_b_i,
    input  logic [DATA_WIDTH-1:0] req1_a_i,
    input  logic [DATA_WIDTH-1:0] req1_b_i,
    output logic [3:0]            alu_operation_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_id_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic [CNT_WIDTH-1:0]  grant0_cnt_o,
    output logic [CNT_WIDTH-1:0]  grant1_cnt_o
);

    state_t                  state;
    logic                    last_grant;
    logic                    id_q;
    logic                    err_q;
    logic [1:0]              grant;
    logic                    accept;
    logic                    sel;
    logic [3:0]              sel_op;
    logic [DATA_WIDTH-1:0]   sel_a;
    logic [DATA_WIDTH-1:0]   sel_b;
    logic                    sel_bad;

    alu_rr_arb u_rr_arb (
        .valid0     (req0_valid_i),
        .valid1     (req1_valid_i),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Ready is also masked by reset so nothing is asserted while reset is held.
    assign req0_ready_o = (state == ST_IDLE) & grant[0] & ~reset;
    assign req1_ready_o = (state == ST_IDLE) & grant[1] & ~reset;
    assign accept       = (state == ST_IDLE) & (grant != 2'b00);
    assign sel          = grant[1];
    assign sel_op       = sel ? req1_op_i : req0_op_i;
    assign sel_a        = sel ? req1_a_i  : req0_a_i;
    assign sel_b        = sel ? req1_b_i  : req0_b_i;
    assign sel_bad      = (sel_op > OP_MAX);

    // The ALU drive registers double as the in-flight latch: loaded on
    // acceptance, visible only during EXEC, cleared when leaving EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            last_grant      <= 1'b1;
            id_q            <= 1'b0;
            err_q           <= 1'b0;
            alu_operation_o <= '0;
            alu_a_o         <= '0;
            alu_b_o         <= '0;
            rsp_valid_o     <= 1'b0;
            rsp_id_o        <= 1'b0;
            rsp_data_o      <= '0;
            rsp_err_o       <= 1'b0;
            grant0_cnt_o    <= '0;
            grant1_cnt_o    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        id_q            <= sel;
                        last_grant      <= sel;
                        err_q           <= sel_bad;
                        alu_operation_o <= sel_bad ? OP_ADD : sel_op;
                        alu_a_o         <= sel_bad ? '0 : sel_a;
                        alu_b_o         <= sel_bad ? '0 : sel_b;
                        if (sel)
                            grant1_cnt_o <= grant1_cnt_o + CNT_WIDTH'(1);
                        else
                            grant0_cnt_o <= grant0_cnt_o + CNT_WIDTH'(1);
                        state           <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_valid_o     <= 1'b1;
                    rsp_id_o        <= id_q;
                    rsp_err_o       <= err_q;
                    rsp_data_o      <= err_q ? '0 : alu_result_i;
                    alu_operation_o <= '0;
                    alu_a_o         <= '0;
                    alu_b_o         <= '0;
                    state           <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_id_o    <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        rsp_data_o  <= '0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed test of alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [3:0]  req0_op_i, req1_op_i;
    logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic [3:0]  alu_operation_o;
    logic [31:0] alu_a_o, alu_b_o, alu_result_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_err_o;
    logic [31:0] rsp_data_o;
    logic [7:0]  grant0_cnt_o, grant1_cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .req0_valid_i    (req0_valid_i),
        .req1_valid_i    (req1_valid_i),
        .req0_ready_o    (req0_ready_o),
        .req1_ready_o    (req1_ready_o),
        .req0_op_i       (req0_op_i),
        .req1_op_i       (req1_op_i),
        .req0_a_i        (req0_a_i),
        .req0_b_i        (req0_b_i),
        .req1_a_i        (req1_a_i),
        .req1_b_i        (req1_b_i),
        .alu_operation_o (alu_operation_o),
        .alu_a_o         (alu_a_o),
        .alu_b_o         (alu_b_o),
        .alu_result_i    (alu_result_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_id_o        (rsp_id_o),
        .rsp_data_o      (rsp_data_o),
        .rsp_err_o       (rsp_err_o),
        .grant0_cnt_o    (grant0_cnt_o),
        .grant1_cnt_o    (grant1_cnt_o)
    );

    // Shared combinational ALU seen by the arbiter.
    always_comb begin
        alu_result_i = 32'h0;
        case (alu_operation_o)
            4'd0: alu_result_i = alu_a_o + alu_b_o;
            4'd1: alu_result_i = alu_a_o - alu_b_o;
            4'd2: alu_result_i = alu_a_o | alu_b_o;
            4'd3: alu_result_i = alu_a_o << alu_b_o[4:0];
            4'd4: alu_result_i = alu_a_o >> alu_b_o[4:0];
            default: alu_result_i = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready0"}, 64'(req0_ready_o), 64'd0);
        check({tag, "_ready1"}, 64'(req1_ready_o), 64'd0);
        check({tag, "_alu_op"}, 64'(alu_operation_o), 64'd0);
        check({tag, "_alu_a"}, 64'(alu_a_o), 64'd0);
        check({tag, "_alu_b"}, 64'(alu_b_o), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        check({tag, "_rsp_data"}, 64'(rsp_data_o), 64'd0);
        check({tag, "_rsp_err"}, 64'(rsp_err_o), 64'd0);
        check({tag, "_rsp_id"}, 64'(rsp_id_o), 64'd0);
        check({tag, "_cnt0"}, 64'(grant0_cnt_o), 64'd0);
        check({tag, "_cnt1"}, 64'(grant1_cnt_o), 64'd0);
    endtask

    // Presents one request, waits for its ready, then drops valid and
    // scrambles the operands. Returns 1 ns into the EXEC cycle.
    task automatic issue(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        if (id == 0) begin
            req0_valid_i = 1'b1; req0_op_i = op; req0_a_i = a; req0_b_i = b;
        end else begin
            req1_valid_i = 1'b1; req1_op_i = op; req1_a_i = a; req1_b_i = b;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready_o : req1_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("issue_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_op_i = 4'd2; req1_op_i = 4'd2;
        req0_a_i = ~a; req0_b_i = ~b; req1_a_i = ~a; req1_b_i = ~b;
    endtask

    // Returns at the negedge of the first cycle with rsp_valid_o high.
    task automatic wait_rsp();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int t_rsp[4];
        logic seen;

        reset = 1'b1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_op_i = 4'd0; req1_op_i = 4'd0;
        req0_a_i = 32'd0; req0_b_i = 32'd0; req1_a_i = 32'd0; req1_b_i = 32'd0;
        rsp_ready_i = 1'b1;

        // Reset state, with a request already pending.
        @(negedge clk);
        req0_valid_i = 1'b1; req0_op_i = 4'd0; req0_a_i = 32'd5; req0_b_i = 32'd7;
        @(negedge clk);
        check_all_zero("reset");

        // Single ADD from req0, accepted in the first cycle after reset.
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("add_ready0", 64'(req0_ready_o), 64'd1);
        check("add_ready1", 64'(req1_ready_o), 64'd0);
        @(posedge clk); #1;
        req0_valid_i = 1'b0; req0_a_i = 32'd99; req0_b_i = 32'd99; req0_op_i = 4'd1;
        @(negedge clk);
        check("add_exec_op", 64'(alu_operation_o), 64'd0);
        check("add_exec_a", 64'(alu_a_o), 64'd5);
        check("add_exec_b", 64'(alu_b_o), 64'd7);
        check("add_exec_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("add_exec_ready0", 64'(req0_ready_o), 64'd0);
        @(negedge clk);
        check("add_rsp_valid", 64'(rsp_valid_o), 64'd1);
        check("add_rsp_id", 64'(rsp_id_o), 64'd0);
        check("add_rsp_data", 64'(rsp_data_o), 64'd12);
        check("add_rsp_err", 64'(rsp_err_o), 64'd0);
        check("add_rsp_alu_a", 64'(alu_a_o), 64'd0);
        check("add_cnt0", 64'(grant0_cnt_o), 64'd1);

        // Both requesters valid continuously: alternate 0,1,0,1 every 3 cycles.
        pulse_reset();
        req0_valid_i = 1'b1; req0_op_i = 4'd2; req0_a_i = 32'hF0; req0_b_i = 32'h0F;
        req1_valid_i = 1'b1; req1_op_i = 4'd3; req1_a_i = 32'h1;  req1_b_i = 32'h4;
        for (int k = 0; k < 4; k++) begin
            wait_rsp();
            t_rsp[k] = cyc;
            check($sformatf("rr_id%0d", k), 64'(rsp_id_o), 64'(k % 2));
            check($sformatf("rr_data%0d", k), 64'(rsp_data_o), (k % 2 == 0) ? 64'hFF : 64'h10);
        end
        check("rr_cnt0", 64'(grant0_cnt_o), 64'd2);
        check("rr_cnt1", 64'(grant1_cnt_o), 64'd2);
        for (int k = 1; k < 4; k++)
            check($sformatf("rr_spacing%0d", k), 64'(t_rsp[k] - t_rsp[k-1]), 64'd3);
        @(posedge clk); #1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;

        // SUB from req1 with back-pressure on the response.
        rsp_ready_i = 1'b0;
        issue(1, 4'd1, 32'd3, 32'd5);
        wait_rsp();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("bp_valid%0d", k), 64'(rsp_valid_o), 64'd1);
            check($sformatf("bp_data%0d", k), 64'(rsp_data_o), 64'hFFFF_FFFE);
            check($sformatf("bp_id%0d", k), 64'(rsp_id_o), 64'd1);
        end
        @(posedge clk); #1;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(rsp_valid_o), 64'd1);
        @(negedge clk);
        check("bp_done_valid", 64'(rsp_valid_o), 64'd0);

        // Illegal op code from req0.
        issue(0, 4'd9, 32'h55, 32'h66);
        @(negedge clk);
        check("err_exec_op", 64'(alu_operation_o), 64'd0);
        check("err_exec_a", 64'(alu_a_o), 64'd0);
        check("err_exec_b", 64'(alu_b_o), 64'd0);
        @(negedge clk);
        check("err_rsp_valid", 64'(rsp_valid_o), 64'd1);
        check("err_rsp_err", 64'(rsp_err_o), 64'd1);
        check("err_rsp_data", 64'(rsp_data_o), 64'd0);

        // Reset during EXEC discards the operation.
        issue(0, 4'd0, 32'd1, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("rst_exec");
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid_o) seen = 1'b1;
        end
        check("rst_exec_no_rsp", 64'(seen), 64'd0);
        issue(0, 4'd4, 32'h80, 32'd3);
        wait_rsp();
        check("rst_fresh_data", 64'(rsp_data_o), 64'h10);
        check("rst_fresh_id", 64'(rsp_id_o), 64'd0);
        check("rst_fresh_cnt0", 64'(grant0_cnt_o), 64'd1);

        // 256 acceptances on req0 wrap its counter.
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            issue(0, 4'd0, 32'(i), 32'd1);
            wait_rsp();
            if (i == 200) check("wrap_data200", 64'(rsp_data_o), 64'd201);
            if (i == 254) check("wrap_cnt255", 64'(grant0_cnt_o), 64'd255);
        end
        check("wrap_cnt0", 64'(grant0_cnt_o), 64'd0);
        check("wrap_cnt1", 64'(grant1_cnt_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
